// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified LC-3b memory port arbiter.
package mem_arb_pkg;

    // Sequencer states: one access at a time, always IDLE -> BUSY -> RESP -> IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    // Which requester owns the access in flight (also the round-robin "last" winner).
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Byte write enables: [1] = high lane (odd byte), [0] = low lane (even byte).
    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_LO   = 2'b01;
    localparam logic [1:0] WE_HI   = 2'b10;
    localparam logic [1:0] WE_WORD = 2'b11;

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane steering for LDB/STB on a two-lane memory word.
// Little-endian: address bit 0 = 0 selects the low byte.
module mem_byte_lane
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              addr0,
    input  logic              is_byte,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [1:0]        mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] rdata_out
);

    localparam int BYTE_W = DATA_W / 2;

    // Pick write enables, replicate the store byte onto both lanes, extract the load byte.
    always_comb begin
        mem_we    = WE_NONE;
        mem_wdata = wdata;
        rdata_out = rdata;
        if (is_byte) begin
            mem_wdata = {wdata[BYTE_W-1:0], wdata[BYTE_W-1:0]};
            rdata_out = {{BYTE_W{1'b0}}, (addr0 ? rdata[DATA_W-1:BYTE_W] : rdata[BYTE_W-1:0])};
            if (we) begin
                mem_we = addr0 ? WE_HI : WE_LO;
            end
        end else if (we) begin
            mem_we = WE_WORD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the single unified memory port.
// Fetch (i_*) and load/store (d_*) share the port; ties are resolved round-robin.
//
// Requester handshake: x_req is raised and held until x_r. x_r is a one-cycle
// pulse in RESP carrying x_rdata; x_rdata then holds until the next completion
// to that requester. Inputs are sampled only on the granting edge, so dropping
// x_req mid-access does not cancel it. A requester that wants no further access
// must have x_req low in the cycle after x_r, because the sequencer is back in
// IDLE then and treats a high x_req as a new request.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_r,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_r,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [1:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_r,
    output logic              err,
    output logic [1:0]        dbg_state
);

    // Watchdog counter only needs to reach TIMEOUT-1; the limit cycle itself triggers the abort.
    localparam int   CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int   TO_LIM = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic TO_EN  = (TIMEOUT > 0) ? 1'b1 : 1'b0;

    arb_state_t        state_q, state_d;
    owner_t            owner_q, last_q, grant_own;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q, byte_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

    logic              grant, busy, timeout_hit, done;
    logic [1:0]        lane_we;
    logic [DATA_W-1:0] lane_wdata, lane_rdata, resp_data;

    mem_byte_lane #(.DATA_W(DATA_W)) u_lane (
        .addr0     (addr_q[0]),
        .is_byte   (byte_q),
        .we        (we_q),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .mem_we    (lane_we),
        .mem_wdata (lane_wdata),
        .rdata_out (lane_rdata)
    );

    assign grant       = (state_q == IDLE) && (i_req || d_req);
    assign busy        = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign timeout_hit = TO_EN && busy && !mem_r && (cnt_q == CNT_W'(TO_LIM));
    assign done        = busy && (mem_r || timeout_hit);
    // An aborted access returns zero rather than whatever is on the bus.
    assign resp_data   = mem_r ? lane_rdata : '0;

    // Pick the winner: a lone requester wins, a tie goes to whoever did not win last.
    always_comb begin
        grant_own = OWN_I;
        if (i_req && d_req) begin
            grant_own = (last_q == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            grant_own = OWN_D;
        end
    end

    // Next-state logic for the IDLE -> BUSY -> RESP sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:           if (grant) state_d = (grant_own == OWN_I) ? BUSY_I : BUSY_D;
            BUSY_I, BUSY_D: if (done)  state_d = RESP;
            RESP:           state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    // State register plus the latched access, watchdog and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            last_q    <= OWN_D;
            addr_q    <= '0;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= grant_own;
                last_q  <= grant_own;
                cnt_q   <= '0;
                if (grant_own == OWN_I) begin
                    addr_q  <= i_addr;
                    we_q    <= 1'b0;
                    byte_q  <= 1'b0;
                    wdata_q <= '0;
                end else begin
                    addr_q  <= d_addr;
                    we_q    <= d_we;
                    byte_q  <= d_byte;
                    wdata_q <= d_wdata;
                end
            end
            if (busy && !mem_r && TO_EN && !timeout_hit) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
            if (done) begin
                if (owner_q == OWN_I) begin
                    i_rdata_q <= resp_data;
                end else begin
                    d_rdata_q <= resp_data;
                end
            end
        end
    end

    assign mem_en    = busy;
    assign mem_we    = busy ? lane_we : WE_NONE;
    assign mem_addr  = busy ? {addr_q[ADDR_W-1:1], 1'b0} : '0;
    assign mem_wdata = busy ? lane_wdata : '0;
    assign i_r       = (state_q == RESP) && (owner_q == OWN_I);
    assign d_r       = (state_q == RESP) && (owner_q == OWN_D);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard queues for responses and memory-side
// access attributes, a memory responder model, and a second instance with a
// short watchdog.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT signals ----------------
    logic        i_req, d_req, d_we, d_byte;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_r, d_r, mem_en, err;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [1:0]  mem_we, dbg_state;
    logic [15:0] mem_rdata;
    logic        mem_r;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_r(i_r), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_r(d_r), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_r(mem_r),
        .err(err), .dbg_state(dbg_state)
    );

    // ---------------- short-watchdog DUT ----------------
    logic        t_i_req;
    logic [15:0] t_i_addr;
    logic        t_i_r, t_d_r, t_mem_en, t_err;
    logic [15:0] t_i_rdata, t_d_rdata, t_mem_addr, t_mem_wdata;
    logic [1:0]  t_mem_we, t_dbg_state;
    logic        t_zero1 = 1'b0;
    logic [15:0] t_zero16 = 16'h0000;
    logic [15:0] t_mem_rdata = 16'hFFFF;

    mem_arbiter #(.TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset),
        .i_req(t_i_req), .i_addr(t_i_addr), .i_r(t_i_r), .i_rdata(t_i_rdata),
        .d_req(t_zero1), .d_we(t_zero1), .d_byte(t_zero1), .d_addr(t_zero16),
        .d_wdata(t_zero16), .d_r(t_d_r), .d_rdata(t_d_rdata),
        .mem_en(t_mem_en), .mem_we(t_mem_we), .mem_addr(t_mem_addr),
        .mem_wdata(t_mem_wdata), .mem_rdata(t_mem_rdata), .mem_r(t_zero1),
        .err(t_err), .dbg_state(t_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [17:0] exp_q[$];    // {check_data, owner_is_d, rdata}
    logic [33:0] mexp_q[$];   // {mem_addr, mem_we, mem_wdata}
    int          pulse_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no response expected completion within bound (t=%0t)", name, $time);
    endtask

    // Response monitor: every x_r pulse pops one expectation.
    always @(negedge clk) begin
        logic [17:0] e;
        if (reset && (i_r || d_r)) begin
            check("r_onehot", 32'(i_r & d_r), 32'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_resp: got i_r=%b d_r=%b expected none", i_r, d_r);
            end else begin
                e = exp_q.pop_front();
                check("resp_owner", 32'(d_r), 32'(e[16]));
                if (e[17]) check("resp_data", 32'(d_r ? d_rdata : i_rdata), 32'(e[15:0]));
            end
            pulse_q.push_back(cyc);
        end
    end

    // Memory responder: raises mem_r after mem_delay BUSY cycles and checks the
    // port attributes on the first BUSY cycle of each access.
    int          mem_delay  = 1;
    bit          mem_always = 1'b0;
    logic [15:0] mem_data   = 16'h0000;
    int          busy_n     = 0;
    assign mem_rdata = mem_data;
    initial mem_r = 1'b0;

    always @(negedge clk) begin
        logic [33:0] m;
        if (mem_en) begin
            busy_n = busy_n + 1;
            if (busy_n == 1 && mexp_q.size() > 0) begin
                m = mexp_q.pop_front();
                check("mem_addr", 32'(mem_addr), 32'(m[33:18]));
                check("mem_we", 32'(mem_we), 32'(m[17:16]));
                if (m[17:16] != 2'b00) check("mem_wdata", 32'(mem_wdata), 32'(m[15:0]));
            end
            mem_r = mem_always || (busy_n >= mem_delay);
        end else begin
            busy_n = 0;
            mem_r  = mem_always;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_access(input logic own_d, input logic we, input logic byt,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             input int delay, input logic [15:0] rdata,
                             input logic chk, input logic [15:0] exp_rdata,
                             input logic [15:0] exp_maddr, input logic [1:0] exp_we,
                             input logic [15:0] exp_wdata);
        bit got = 0;
        mem_delay  = delay;
        mem_always = 1'b0;
        mem_data   = rdata;
        exp_q.push_back({chk, own_d, exp_rdata});
        mexp_q.push_back({exp_maddr, exp_we, exp_wdata});
        @(posedge clk); #1;
        if (own_d) begin
            d_req = 1'b1; d_we = we; d_byte = byt; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (own_d ? d_r : i_r) begin
                got = 1;
                break;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        if (!got) bound_fail("access_done");
    endtask

    // ---------------- global time limit ----------------
    initial begin
        #200000;
        n_err++;
        $display("FAIL global_timeout: got no end of test expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0, np, tbusy;
        bit got;
        reset = 1'b0;
        i_req = 0; d_req = 0; d_we = 0; d_byte = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        t_i_req = 0; t_i_addr = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_r", 32'({i_r, d_r}), 32'd0);
        check("rst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
        check("rst_err", 32'({err, t_err}), 32'd0);
        reset = 1'b1;

        // Both requesters together from reset: I, D, I, D with mem_r always high
        mem_always = 1'b1;
        mem_data   = 16'h5A5A;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b1, 1'b0, 16'h5A5A});
            exp_q.push_back({1'b1, 1'b1, 16'h5A5A});
            mexp_q.push_back({16'h0100, 2'b00, 16'h0000});
            mexp_q.push_back({16'h0200, 2'b00, 16'h0000});
        end
        pulse_q.delete();
        @(posedge clk); #1;
        t0 = cyc;
        i_addr = 16'h0100; d_addr = 16'h0200; d_we = 0; d_byte = 0;
        i_req = 1'b1; d_req = 1'b1;
        np = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (i_r || d_r) np++;
            if (np == 4) break;
        end
        i_req = 1'b0; d_req = 1'b0;
        #1;
        if (np != 4 || pulse_q.size() != 4) begin
            bound_fail("rr_pulses");
        end else begin
            check("min_latency", 32'(pulse_q[1-1] - t0), 32'd2);
            check("rr_gap1", 32'(pulse_q[1] - pulse_q[0]), 32'd3);
            check("rr_gap2", 32'(pulse_q[2] - pulse_q[1]), 32'd3);
            check("rr_gap3", 32'(pulse_q[3] - pulse_q[2]), 32'd3);
        end

        // Fetch alone at odd address, ready after 3 BUSY cycles
        do_access(1'b0, 1'b0, 1'b0, 16'h3001, 16'h0000, 3, 16'h1234,
                  1'b1, 16'h1234, 16'h3000, 2'b00, 16'h0000);
        // STB to odd address
        do_access(1'b1, 1'b1, 1'b1, 16'h4003, 16'hABCD, 1, 16'h0000,
                  1'b0, 16'h0000, 16'h4002, 2'b10, 16'hCDCD);
        check("i_rdata_hold", 32'(i_rdata), 32'h1234);
        // LDB from even address
        do_access(1'b1, 1'b0, 1'b1, 16'h4002, 16'h0000, 2, 16'h80F7,
                  1'b1, 16'h00F7, 16'h4002, 2'b00, 16'h0000);
        // LDB from odd address
        do_access(1'b1, 1'b0, 1'b1, 16'h4003, 16'h0000, 1, 16'h80F7,
                  1'b1, 16'h0080, 16'h4002, 2'b00, 16'h0000);
        // Word store to odd address: silently aligned
        do_access(1'b1, 1'b1, 1'b0, 16'h5001, 16'h1357, 2, 16'h0000,
                  1'b0, 16'h0000, 16'h5000, 2'b11, 16'h1357);
        // STB to even address
        do_access(1'b1, 1'b1, 1'b1, 16'h4000, 16'h0012, 1, 16'h0000,
                  1'b0, 16'h0000, 16'h4000, 2'b01, 16'h1212);
        // Word load
        do_access(1'b1, 1'b0, 1'b0, 16'h6000, 16'h0000, 4, 16'hBEEF,
                  1'b1, 16'hBEEF, 16'h6000, 2'b00, 16'h0000);
        check("no_err_main", 32'(err), 32'd0);

        // Watchdog abort on the TIMEOUT=4 instance (its mem_r is tied low)
        @(posedge clk); #1;
        t_i_addr = 16'h7000;
        t_i_req  = 1'b1;
        tbusy = 0;
        got   = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (t_mem_en) tbusy++;
            if (t_i_r) begin
                got = 1;
                check("to_rdata", 32'(t_i_rdata), 32'h0000);
                break;
            end
        end
        t_i_req = 1'b0;
        if (!got) bound_fail("to_done");
        check("to_busy_cycles", 32'(tbusy), 32'd4);
        check("to_err_set", 32'(t_err), 32'd1);
        repeat (5) @(negedge clk);
        check("to_err_sticky", 32'(t_err), 32'd1);

        // Reset in the middle of BUSY_D: immediate abort, no d_r
        mem_delay  = 50;
        mem_always = 1'b0;
        mem_data   = 16'h9999;
        mexp_q.push_back({16'h4444, 2'b00, 16'h0000});
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 0; d_byte = 0; d_addr = 16'h4444;
        np = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_en) np++;
            if (np == 2) break;
        end
        if (np != 2) bound_fail("busy_d_reach");
        check("busy_d_state", 32'(dbg_state), 32'(BUSY_D));
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_mem_en", 32'(mem_en), 32'd0);
        check("rst_async_state", 32'(dbg_state), 32'd0);
        check("rst_d_rdata", 32'(d_rdata), 32'd0);
        check("rst_err_clear", 32'(t_err), 32'd0);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Normal fetch after release
        do_access(1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 1, 16'h4321,
                  1'b1, 16'h4321, 16'h1000, 2'b00, 16'h0000);

        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("mexp_q_drained", 32'(mexp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single unified LC-3b memory port. It shares the port between the instruction-fetch path and the load/store datapath. It runs each access through a request/busy/response sequence, waiting on the memory ready flag. It also steers byte lanes for LDB/STB and flags accesses the memory never completes.

## Interface
- `ADDR_W`, default 16: address width in bits.
- `DATA_W`, default 16: data word width; fixed at two byte lanes.
- `TIMEOUT`, default 255: maximum BUSY cycles before abort; 0 disables the watchdog.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held high until `i_r`.
- `i_addr`  in  ADDR_W  fetch address; bit 0 ignored.
- `i_r`  out  1  one-cycle fetch completion pulse.
- `i_rdata`  out  DATA_W  fetched word; valid while `i_r` is high.
- `d_req`  in  1  data request; held high until `d_r`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_byte`  in  1  1 = byte access (LDB/STB), 0 = word access.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data; bits [7:0] are used for a byte store.
- `d_r`  out  1  one-cycle data completion pulse.
- `d_rdata`  out  DATA_W  load data; a byte load returns the byte zero-extended.
- `mem_en`  out  1  memory access active.
- `mem_we`  out  2  byte write enables; [1] = high lane, [0] = low lane.
- `mem_addr`  out  ADDR_W  word-aligned address, bit 0 always 0.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rdata`  in  DATA_W  read data; valid when `mem_r` is high.
- `mem_r`  in  1  memory ready (the R flag).
- `err`  out  1  sticky timeout flag.

## Operation
- States:
  - IDLE: no access in progress.
  - BUSY_I: fetch access in progress.
  - BUSY_D: data access in progress.
  - RESP: one-cycle completion.
- IDLE:
  - Only one request high: grant it.
  - Both high: round-robin, granting the requester that did not win last.
  - `last` bit resets to "data", so the first tie goes to fetch.
  - At the granting edge: latch address, we, byte, wdata and owner; go to BUSY_I or BUSY_D.
- BUSY_x:
  - `mem_en`=1; `mem_addr`, `mem_we`, `mem_wdata` are driven from the latched registers.
  - Requester inputs are ignored after the grant.
  - `mem_r`=1: capture `mem_rdata` into the response register and go to RESP.
- RESP:
  - `mem_en`=0.
  - The owner's `x_r`=1 for exactly one cycle, with `x_rdata` from the response register.
  - Next state is IDLE.
  - `x_rdata` holds its value until the next completion to that requester.
- Byte lane steering is based on latched `addr[0]`:
  - Word store: `mem_we`=2'b11, `mem_wdata`=`d_wdata`.
  - Byte store: `mem_we`=2'b01 if addr[0]=0, 2'b10 if addr[0]=1; `mem_wdata`={wdata[7:0], wdata[7:0]}.
  - Byte load: `d_rdata`={8'h00, selected byte}.
  - Loads and all fetches: `mem_we`=2'b00.
  - Word access with addr[0]=1: aligned down silently, no error.
- Watchdog:
  - The counter clears on entry to BUSY and increments each BUSY cycle without `mem_r`.
  - When the count reaches TIMEOUT (TIMEOUT>0), go to RESP with response data 16'h0000 and set `err`.
  - `err` is cleared only by reset.
- `req` dropped mid-access: the access still completes and `x_r` still pulses.

## Timing
- Reset (async, `reset`=0): state IDLE; all outputs 0; `last`=data; counter 0; `err`=0; response registers 0.
- Reset mid-access aborts immediately: `mem_en` drops asynchronously and no `x_r` pulse is produced.
- Request at edge E0: BUSY from E0, `mem_en` high in cycle 1.
- `mem_r` seen at edge Ek: RESP in the following cycle, then IDLE.
- Minimum latency, `req` to `x_r`, is 2 cycles (`mem_r` already high in the first BUSY cycle).
- Back-to-back accesses: a requester wanting none must have `req` low in the cycle after its `x_r`. A `req` still high in the IDLE cycle is a new request.
- Back-to-back throughput: one access every 3 cycles minimum (IDLE, BUSY, RESP).
- `mem_r` while IDLE or RESP: ignored.
- Both requests held continuously: grants alternate I, D, I, D…

## Structure
- Package `mem_arb_pkg`:
  - State encoding typedef (IDLE, BUSY_I, BUSY_D, RESP).
  - Owner typedef (OWN_I, OWN_D).
  - `mem_we` constants WE_NONE, WE_LO, WE_HI, WE_WORD.
- Sub-module `mem_byte_lane`: purely combinational store/load lane steering (addr[0], byte, we, wdata, rdata → mem_we, mem_wdata, rdata_out).

## Test plan
- Fetch alone, addr 16'h3001, memory ready after 3 BUSY cycles with rdata 16'h1234:
  - `mem_addr`=16'h3000 and `mem_we`=00.
  - `i_r` pulses once with `i_rdata`=16'h1234; `d_r` stays 0.
- STB at addr 16'h4003 with wdata 16'hABCD: `mem_we`=2'b10, `mem_wdata`=16'hCDCD, `mem_addr`=16'h4002.
- LDB at addr 16'h4002 with mem_rdata 16'h80F7: `d_rdata`=16'h00F7.
- `i_req` and `d_req` raised together after reset, held high, `mem_r` always 1:
  - Grant order is I, D, I, D.
  - `x_r` pulses are 3 cycles apart.
- TIMEOUT=4, `mem_r` held 0:
  - Abort after 4 BUSY cycles.
  - `i_r` pulses with 16'h0000; `err`=1 and stays 1 until reset.
- `reset` pulled low in the middle of BUSY_D: `mem_en`=0 and state is IDLE immediately; no `d_r` pulse; normal fetch works after release.
